// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: instruction fetch stage feeding decode.
// Owns the fetch PC and issues in-order requests to instruction memory.
// Responses are buffered in a small FIFO that is presented to decode.
// Requests use a credit rule: FIFO entries plus in-flight requests never exceed FIFO_DEPTH.
// A redirect flushes the FIFO, retargets fetch, and marks in-flight responses for dropping.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN.
//   When defined, a misaligned redirect halts fetch and raises fetch_misalign_o.
//   When undefined, the low two redirect bits are ignored.
//
// Handshakes:
//   imem request: accepted on the cycle where imem_req_o && imem_gnt_i.
//     While a request is ungranted, imem_addr_o holds steady.
//     A redirect may retarget an ungranted request.
//   Decode output: an instruction is consumed on the cycle where valid && decode_ready_i.
//     Nothing is consumed while redirect_i is high.
module riscv_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        risc_clk,
  input  logic        risc_rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        decode_ready_i,
  output logic [31:0] instruction,
  output logic [31:0] pc_o,
  output logic        valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [63:0]   mem [FIFO_DEPTH];  // {pc, instruction}
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_tgt;
  logic          halted;
  logic          grant;
  logic          drop;
  logic          push;
  logic          pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_tgt = redirect_pc_i;
  assign halted       = fetch_misalign_o;

  // Misalign flag: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge risc_clk) begin
    if (risc_rst) begin
      fetch_misalign_o <= 1'b0;
    end else if (redirect_i) begin
      fetch_misalign_o <= |redirect_pc_i[1:0];
    end
  end
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc_i[1:0];
  assign redirect_tgt   = {redirect_pc_i[31:2], 2'b00};
  assign halted         = 1'b0;
`endif

  // Credit: a slot is reserved for every buffered or in-flight instruction.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_o  = !risc_rst && !halted && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc;

  assign grant = imem_req_o && imem_gnt_i;
  assign drop  = imem_rvalid_i && (drop_cnt != '0);
  assign push  = imem_rvalid_i && !drop && !redirect_i;
  assign valid = (count != '0);
  assign pop   = valid && decode_ready_i && !redirect_i;

  // No bypass: decode only ever sees the registered FIFO head.
  assign instruction = valid ? mem[rd_ptr][31:0]  : NOP;
  assign pc_o        = valid ? mem[rd_ptr][63:32] : 32'h0;

  // In-flight count after this cycle's grant and response.
  always_comb begin
    outstanding_nxt = outstanding;
    if (grant && !imem_rvalid_i) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (!grant && imem_rvalid_i) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  // FIFO storage; it holds no reset because occupancy is tracked separately.
  always_ff @(posedge risc_clk) begin
    if (push) begin
      mem[wr_ptr] <= {resp_pc, imem_rdata_i};
    end
  end

  // PCs, credits, drop counter and FIFO pointers; redirect overrides push and pop.
  always_ff @(posedge risc_clk) begin
    if (risc_rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        fetch_pc <= redirect_tgt;
        resp_pc  <= redirect_tgt;
        drop_cnt <= outstanding_nxt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb_riscv_fetch_stage: directed bench for riscv_fetch_stage.
// The instruction memory model answers each granted address in order after `lat` cycles.
// The reference model tracks the stage as queues:
//   - requests in flight, each with a stale flag;
//   - buffered PCs, held in exp_q.
// The model's outputs are compared against the design on every falling edge.
// Literal checks pin down reset, latency, credit stall, redirect targets and PC wrap.
module tb_riscv_fetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic        risc_clk = 1'b0;
  logic        risc_rst;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        decode_ready;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] instruction;
  logic [31:0] pc_o;
  logic        valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  always #5 risc_clk = ~risc_clk;

  riscv_fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .risc_clk      (risc_clk),
    .risc_rst      (risc_rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .decode_ready_i(decode_ready),
    .instruction   (instruction),
    .pc_o          (pc_o),
    .valid         (valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign_o(fetch_misalign)
`endif
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic check_en = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h0001_0001) ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- instruction memory responder ----------------
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          lat = 1;
  logic        s_grant;
  logic [31:0] s_addr;

  always @(negedge risc_clk) begin
    s_grant = imem_req_o && imem_gnt;
    s_addr  = imem_addr_o;
  end

  always @(posedge risc_clk) begin
    cyc++;
    if (risc_rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (imem_rvalid && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (s_grant) begin
        pend_addr.push_back(s_addr);
        pend_due.push_back(cyc + lat - 1);
      end
    end
    #2;
    if (!risc_rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(pend_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_fetch_pc;
  logic [31:0] m_inflight[$];
  bit          m_stale[$];
  logic [31:0] exp_q[$];
  logic        m_halt;
  logic        m_req;
  logic        m_pop;
  logic [31:0] m_a;
  bit          m_s;

  always @(posedge risc_clk) begin
    if (risc_rst) begin
      m_fetch_pc = RST_PC;
      m_inflight.delete();
      m_stale.delete();
      exp_q.delete();
      m_halt = 1'b0;
    end else begin
      m_req = !m_halt && ((exp_q.size() + m_inflight.size()) < DEPTH);
      m_pop = (exp_q.size() > 0) && decode_ready && !redirect;
      if (m_pop) void'(exp_q.pop_front());
      if (imem_rvalid && m_inflight.size() > 0) begin
        m_a = m_inflight.pop_front();
        m_s = m_stale.pop_front();
        if (!m_s && !redirect) exp_q.push_back(m_a);
      end
      if (m_req && imem_gnt) begin
        m_inflight.push_back(m_fetch_pc);
        m_stale.push_back(1'b0);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redirect) begin
        exp_q.delete();
        foreach (m_stale[i]) m_stale[i] = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        m_fetch_pc = redirect_pc;
        m_halt     = |redirect_pc[1:0];
`else
        m_fetch_pc = {redirect_pc[31:2], 2'b00};
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic c_req;
  logic c_valid;

  always @(negedge risc_clk) begin
    if (check_en) begin
      c_req   = !risc_rst && !m_halt && ((exp_q.size() + m_inflight.size()) < DEPTH);
      c_valid = exp_q.size() > 0;
      chk("imem_req", {31'b0, imem_req_o}, {31'b0, c_req});
      if (c_req) chk("imem_addr", imem_addr_o, m_fetch_pc);
      chk("valid", {31'b0, valid}, {31'b0, c_valid});
      chk("pc_o", pc_o, c_valid ? exp_q[0] : 32'h0);
      chk("instruction", instruction, c_valid ? instr_of(exp_q[0]) : NOP);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_halt});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge risc_clk);
      #2;
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    @(negedge risc_clk);
    while (valid !== 1'b1 && k < budget) begin
      @(negedge risc_clk);
      k++;
    end
    if (valid !== 1'b1) begin
      n_checks++;
      $display("FAIL %s: valid=%b expected 1 within %0d cycles", name, valid, budget);
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step(1);
    redirect    = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0]  gpat = 8'b1011_0010;
  logic [4:0]  rpat = 5'b10110;
  logic [31:0] exp_pc;

  initial begin
    risc_rst = 1'b1; imem_gnt = 1'b1; decode_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(posedge risc_clk); #2;
    check_en = 1'b1;
    step(1);
    @(negedge risc_clk);
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    chk("rst_addr", imem_addr_o, RST_PC);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instruction, NOP);
    chk("rst_pc", pc_o, 32'h0);

    // Reset release and first-fetch latency
    step(1); risc_rst = 1'b0;
    @(negedge risc_clk);
    chk("first_req", {31'b0, imem_req_o}, 32'h1);
    chk("first_addr", imem_addr_o, 32'h0);
    step(1);
    @(negedge risc_clk);
    chk("second_addr", imem_addr_o, 32'h4);
    chk("no_bypass_valid", {31'b0, valid}, 32'h0);
    step(1);
    @(negedge risc_clk);
    chk("first_valid", {31'b0, valid}, 32'h1);
    chk("first_pc", pc_o, 32'h0);
    chk("first_instr", instruction, 32'hC0DE_5A5A);
    step(1);
    @(negedge risc_clk);
    chk("second_pc", pc_o, 32'h4);
    chk("second_instr", instruction, 32'hC0DA_5A5E);
    step(6);

    // Decode stall: credits exhaust, head held
    decode_ready = 1'b0;
    do_redirect(32'h40);
    step(10);
    @(negedge risc_clk);
    chk("stall_req", {31'b0, imem_req_o}, 32'h0);
    chk("stall_valid", {31'b0, valid}, 32'h1);
    chk("stall_pc", pc_o, 32'h40);
    step(1); decode_ready = 1'b1;
    @(negedge risc_clk);
    chk("stall_head_pc", pc_o, 32'h40);
    step(1);
    @(negedge risc_clk);
    chk("resume_pc", pc_o, 32'h44);
    step(8);

    // Redirect with several responses outstanding
    lat = 3;
    step(8);
    do_redirect(32'h100);
    wait_valid("redir_100_valid", 30);
    chk("redir_100_pc", pc_o, 32'h100);
    step(6);

    // Redirect in a cycle with both grant and response
    lat = 1;
    step(8);
    do_redirect(32'h200);
    wait_valid("redir_200_valid", 30);
    chk("redir_200_pc", pc_o, 32'h200);
    step(4);

    // Irregular grants and decode readiness, redirect during a stalled request
    lat = 2;
    for (int i = 0; i < 24; i++) begin
      imem_gnt     = gpat[i % 8];
      decode_ready = rpat[i % 5];
      redirect     = (i == 10);
      redirect_pc  = 32'h300;
      step(1);
    end
    imem_gnt = 1'b1; decode_ready = 1'b1; redirect = 1'b0;
    step(10);

    // Streaming with one buffered entry, PC wrap
    lat = 1;
    do_redirect(32'hFFFF_FFF0);
    wait_valid("wrap_valid", 30);
    chk("wrap_first_pc", pc_o, 32'hFFFF_FFF0);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      @(negedge risc_clk);
      exp_pc = 32'hFFFF_FFF0 + 32'(4 * k);
      chk("wrap_stream_valid", {31'b0, valid}, 32'h1);
      chk("wrap_stream_pc", pc_o, exp_pc);
    end
    step(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect halts fetch until an aligned redirect
    step(1);
    do_redirect(32'h102);
    @(negedge risc_clk);
    chk("misalign_set", {31'b0, fetch_misalign}, 32'h1);
    chk("misalign_req", {31'b0, imem_req_o}, 32'h0);
    step(6);
    @(negedge risc_clk);
    chk("misalign_held", {31'b0, fetch_misalign}, 32'h1);
    chk("misalign_valid", {31'b0, valid}, 32'h0);
    step(1);
    do_redirect(32'h200);
    @(negedge risc_clk);
    chk("misalign_clear", {31'b0, fetch_misalign}, 32'h0);
    chk("misalign_resume_req", {31'b0, imem_req_o}, 32'h1);
    chk("misalign_resume_addr", imem_addr_o, 32'h200);
    wait_valid("misalign_resume_valid", 30);
    chk("misalign_resume_pc", pc_o, 32'h200);
`else
    // Low redirect bits are ignored
    step(1);
    do_redirect(32'h203);
    wait_valid("align_valid", 30);
    chk("align_pc", pc_o, 32'h200);
`endif
    step(4);

    // Reset in the middle of traffic
    lat = 3;
    step(5);
    risc_rst = 1'b1;
    step(2);
    risc_rst = 1'b0;
    wait_valid("rerst_valid", 30);
    chk("rerst_pc", pc_o, RST_PC);
    step(6);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
